// File: rtl/assoc_mem_rsp.sv
// Fully associative 64-bit key/value table: parallel tag match, lowest-free allocation, drop-on-full.
// Latency: read data, rhit and rvalid one cycle after ren; writes visible to reads from the next cycle.
// Backpressure: none; a write that misses a full table is discarded and flagged by a one-cycle wdrop pulse.
module assoc_mem_rsp #(
    parameter int          DEPTH     = 8,
    parameter logic [63:0] MISS_DATA = 64'h0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wen,
    input  logic                         ren,
    input  logic [63:0]                  wdin,
    input  logic [63:0]                  addr,
    input  logic                         clr,
    output logic [63:0]                  rdout,
    output logic                         rvalid,
    output logic                         rhit,
    output logic                         wdrop,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [63:0]      tag_q  [DEPTH];
    logic [63:0]      data_q [DEPTH];

    logic [63:0]      rdout_q, rdout_d;
    logic             rhit_q, rhit_d;
    logic             rvalid_q;
    logic             wdrop_q, wdrop_d;

    logic [DEPTH-1:0] match;
    logic             hit;
    logic [IW-1:0]    hit_idx;
    logic [IW-1:0]    free_idx;
    logic [CW-1:0]    cnt;
    logic             is_full;
    logic             do_wr, wr_upd, wr_alloc;

    // Lookup: tags are unique, so hit_idx is exact; descending loops leave the lowest index
    always_comb begin
        match    = '0;
        hit_idx  = '0;
        free_idx = '0;
        cnt      = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            match[i] = valid_q[i] && (tag_q[i] == addr);
            if (match[i]) begin
                hit_idx = IW'(i);
            end
            if (!valid_q[i]) begin
                free_idx = IW'(i);
            end
            cnt = cnt + CW'(valid_q[i]);
        end
        hit     = |match;
        is_full = (cnt == CW'(DEPTH));
    end

    // Clear wins over a same-cycle write; hit-overwrite wins over allocation
    always_comb begin
        do_wr    = wen && !clr;
        wr_upd   = do_wr && hit;
        wr_alloc = do_wr && !hit && !is_full;
        wdrop_d  = do_wr && !hit && is_full;

        valid_d = valid_q;
        if (clr) begin
            valid_d = '0;
        end else if (wr_alloc) begin
            valid_d[free_idx] = 1'b1;
        end

        rdout_d = rdout_q;
        rhit_d  = rhit_q;
        if (ren) begin
            rdout_d = hit ? data_q[hit_idx] : MISS_DATA;
            rhit_d  = hit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            rdout_q  <= '0;
            rhit_q   <= 1'b0;
            rvalid_q <= 1'b0;
            wdrop_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rdout_q  <= rdout_d;
            rhit_q   <= rhit_d;
            rvalid_q <= ren;
            wdrop_q  <= wdrop_d;
        end
    end

    // Tag/data storage is qualified by valid_q, so it needs no reset
    always_ff @(posedge clk) begin
        if (wr_upd) begin
            data_q[hit_idx] <= wdin;
        end else if (wr_alloc) begin
            tag_q[free_idx]  <= addr;
            data_q[free_idx] <= wdin;
        end
    end

    assign rdout  = rdout_q;
    assign rhit   = rhit_q;
    assign rvalid = rvalid_q;
    assign wdrop  = wdrop_q;
    assign count  = cnt;
    assign full   = is_full;

endmodule

// File: tb/tb_assoc_mem_rsp.sv
// Bench for assoc_mem_rsp: directed scenarios plus random traffic against an associative-array model.
module tb_assoc_mem_rsp;

    localparam int          DEPTH = 8;
    localparam int          CW    = $clog2(DEPTH + 1);
    localparam logic [63:0] MISS  = 64'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wen, ren, clr;
    logic [63:0]   wdin, addr;
    logic [63:0]   rdout;
    logic          rvalid, rhit, wdrop, full;
    logic [CW-1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mdl [logic [63:0]];
    logic [63:0] exp_rdout;
    logic        exp_rhit;
    logic [63:0] pool [12];

    assoc_mem_rsp #(.DEPTH(DEPTH), .MISS_DATA(MISS)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .wdin(wdin), .addr(addr),
        .clr(clr), .rdout(rdout), .rvalid(rvalid), .rhit(rhit), .wdrop(wdrop),
        .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One cycle of traffic: predict from the model, apply, then compare after the edge
    task automatic step(input logic w, input logic r, input logic c,
                        input logic [63:0] a, input logic [63:0] d);
        bit   ex;
        logic exp_wdrop;
        @(negedge clk);
        wen = w; ren = r; clr = c; addr = a; wdin = d;
        ex        = mdl.exists(a);
        exp_wdrop = w && !c && !ex && (mdl.num() == DEPTH);
        if (r) begin
            exp_rhit  = ex;
            exp_rdout = ex ? mdl[a] : MISS;
        end
        if (c) mdl.delete();
        else if (w && (ex || mdl.num() < DEPTH)) mdl[a] = d;
        @(posedge clk);
        #1;
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
        chk("rvalid", 64'(rvalid), 64'(r));
        chk("rhit",   64'(rhit),   64'(exp_rhit));
        chk("rdout",  rdout,       exp_rdout);
        chk("wdrop",  64'(wdrop),  64'(exp_wdrop));
        chk("count",  64'(count),  64'(mdl.num()));
        chk("full",   64'(full),   64'(mdl.num() == DEPTH));
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_rdout"},  rdout,       64'h0);
        chk({tag, "_rhit"},   64'(rhit),   64'h0);
        chk({tag, "_rvalid"}, 64'(rvalid), 64'h0);
        chk({tag, "_wdrop"},  64'(wdrop),  64'h0);
        chk({tag, "_count"},  64'(count),  64'h0);
        chk({tag, "_full"},   64'(full),   64'h0);
    endtask

    initial begin
        logic [63:0] k;
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clr = 1'b0; wdin = '0; addr = '0;
        exp_rdout = '0; exp_rhit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pool[i]     = {$urandom, $urandom};
            pool[i + 6] = pool[i] ^ 64'h8000_0000_0000_0000;
        end

        repeat (2) @(posedge clk);
        #1 chk_outs_zero("reset");
        @(negedge clk) rst_n = 1'b1;

        // Basic write then read, and a never-written read
        step(1, 0, 0, 64'h1234, 64'hA5A5);
        step(0, 0, 0, 64'h0, 64'h0);
        step(0, 1, 0, 64'h1234, 64'h0);
        chk("basic_rdout", rdout, 64'hA5A5);
        chk("basic_count", 64'(count), 64'd1);
        step(0, 1, 0, 64'hDEAD, 64'h0);
        chk("miss_rhit", 64'(rhit), 64'h0);

        // Fill, overflow, overwrite while full
        step(0, 0, 1, 64'h0, 64'h0);
        for (int i = 0; i < DEPTH; i++) step(1, 0, 0, 64'h100 + 64'(i), 64'(i) + 64'h50);
        step(1, 0, 0, 64'h999, 64'h77);
        chk("drop_pulse", 64'(wdrop), 64'h1);
        step(0, 1, 0, 64'h999, 64'h0);
        chk("drop_gone", 64'(wdrop), 64'h0);
        step(1, 0, 0, 64'h100, 64'hBEEF);
        step(0, 1, 0, 64'h100, 64'h0);
        chk("full_overwrite", rdout, 64'hBEEF);

        // Read-before-write at the same address
        step(0, 0, 1, 64'h0, 64'h0);
        step(1, 0, 0, 64'h10, 64'h1);
        step(1, 1, 0, 64'h10, 64'h2);
        chk("rbw_old", rdout, 64'h1);
        step(0, 1, 0, 64'h10, 64'h0);
        chk("rbw_new", rdout, 64'h2);

        // Clear: same-cycle read sees old contents; clear beats a same-cycle write
        for (int i = 0; i < 3; i++) step(1, 0, 0, 64'h200 + 64'(i), 64'h300 + 64'(i));
        step(0, 1, 1, 64'h201, 64'h0);
        chk("clr_preread", rdout, 64'h301);
        step(0, 1, 0, 64'h200, 64'h0);
        step(1, 0, 1, 64'h202, 64'h9);
        chk("clr_wen_count", 64'(count), 64'h0);

        // Random traffic over a small key pool with top-bit aliases
        for (int n = 0; n < 1500; n++) begin
            k = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : pool[$urandom_range(0, 11)];
            step(1'($urandom), 1'($urandom), ($urandom_range(0, 39) == 0), k, {$urandom, $urandom});
        end

        // Asynchronous reset with the table full and a write in flight
        step(0, 0, 1, 64'h0, 64'h0);
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, pool[i], 64'hC0 + 64'(i));
        @(negedge clk);
        wen = 1'b1; ren = 1'b1; addr = pool[0]; wdin = 64'h1;
        #2 rst_n = 1'b0;
        #1 chk_outs_zero("async_rst");
        mdl.delete();
        exp_rdout = '0; exp_rhit = 1'b0;
        wen = 1'b0; ren = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, pool[i], 64'h0);
        chk("post_rst_miss", 64'(rhit), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
